// File: rtl/saph_num_unpack_stream.sv
// rtl/saph_num_unpack_stream.sv - streaming multi-channel bit-field unpacker
// Two-stage valid/ready pipeline: stage 1 extracts fields, stage 2 expands them to unpack_width.
module saph_num_unpack_stream #(
   parameter int pack_width   = 16,
   parameter int unpack_width = 8,
   parameter int channels     = 4,
   localparam int pack_exp    = $clog2(pack_width),
   localparam int unpack_exp  = $clog2(unpack_width + 1),
   localparam int ch_exp      = (channels > 1) ? $clog2(channels) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cfg_we,
   input  logic [ch_exp-1:0]                cfg_ch,
   input  logic [pack_exp-1:0]              cfg_pos,
   input  logic [unpack_exp-1:0]            cfg_width,
   input  logic [1:0]                       cfg_mode,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [pack_width-1:0]            in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [channels*unpack_width-1:0] out_data,
   output logic                             busy
);

   localparam int idx_w = (unpack_width > 1) ? $clog2(unpack_width) : 1;

   logic [pack_exp-1:0]                         r_fmt_pos  [channels];
   logic [unpack_exp-1:0]                       r_fmt_w    [channels];
   logic [1:0]                                  r_fmt_mode [channels];

   logic                                        r_s1_valid;
   logic [channels-1:0][unpack_width-1:0]       r_s1_raw;
   logic [channels-1:0][unpack_exp-1:0]         r_s1_w;
   logic [channels-1:0][1:0]                    r_s1_mode;

   logic                                        r_s2_valid;
   logic [channels-1:0][unpack_width-1:0]       r_out;

   logic [unpack_exp-1:0]                       w_cfg_w;
   logic [channels-1:0][unpack_width-1:0]       w_raw;
   logic [channels-1:0][unpack_width-1:0]       w_exp;
   logic                                        w_s2_adv;
   logic                                        w_s1_move;
   logic                                        w_accept;

   assign w_cfg_w   = (cfg_width > unpack_exp'(unpack_width)) ? unpack_exp'(unpack_width) : cfg_width;
   assign w_s2_adv  = !r_s2_valid || out_ready;
   assign w_s1_move = r_s1_valid && w_s2_adv;
   assign in_ready  = rst_n && (!r_s1_valid || w_s1_move);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = r_s2_valid;
   assign out_data  = r_out;
   assign busy      = r_s1_valid || r_s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < channels; c++) begin
            r_fmt_pos[c]  <= '0;
            r_fmt_w[c]    <= '0;
            r_fmt_mode[c] <= '0;
         end
      end else if (cfg_we && (int'(cfg_ch) < channels)) begin
         r_fmt_pos[cfg_ch]  <= cfg_pos;
         r_fmt_w[cfg_ch]    <= w_cfg_w;
         r_fmt_mode[cfg_ch] <= cfg_mode;
      end
   end

   // Field bits that fall above the packed word read as zero.
   always_comb begin
      int idx;
      idx   = 0;
      w_raw = '0;
      for (int c = 0; c < channels; c++) begin
         for (int i = 0; i < unpack_width; i++) begin
            idx = int'(r_fmt_pos[c]) + i;
            if ((idx < pack_width) && (i < int'(r_fmt_w[c])))
               w_raw[c][i] = in_data[pack_exp'(idx)];
         end
      end
   end

   // Each output bit selects one raw bit (k) or zero (k < 0), chosen by mode.
   always_comb begin
      int w_len;
      int k;
      w_len = 0;
      k     = 0;
      w_exp = '0;
      for (int c = 0; c < channels; c++) begin
         w_len = int'(r_s1_w[c]);
         for (int i = 0; i < unpack_width; i++) begin
            k = -1;
            if (w_len != 0) begin
               case (r_s1_mode[c])
                  2'd0:    k = w_len - 1 - ((unpack_width - 1 - i) % w_len);
                  2'd1:    k = i;
                  2'd2:    k = (i < w_len) ? i : w_len - 1;
                  default: k = i - (unpack_width - w_len);
               endcase
            end
            if (k >= 0)
               w_exp[c][i] = r_s1_raw[c][idx_w'(k)];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_raw   <= '0;
         r_s1_w     <= '0;
         r_s1_mode  <= '0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_raw   <= w_raw;
         for (int c = 0; c < channels; c++) begin
            r_s1_w[c]    <= r_fmt_w[c];
            r_s1_mode[c] <= r_fmt_mode[c];
         end
      end else if (w_s1_move) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_out      <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid)
            r_out <= w_exp;
      end
   end

endmodule

// File: tb/tb_saph_num_unpack_stream.sv
// tb/tb_saph_num_unpack_stream.sv - self-checking bench for saph_num_unpack_stream
// Scenario tasks compare DUT output against constants or a queue-based format model.
module tb_saph_num_unpack_stream;

   localparam int P  = 16;
   localparam int U  = 8;
   localparam int C  = 3;
   localparam int PE = 4;
   localparam int UE = 4;
   localparam int CE = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           cfg_we = 1'b0;
   logic [CE-1:0]  cfg_ch = '0;
   logic [PE-1:0]  cfg_pos = '0;
   logic [UE-1:0]  cfg_width = '0;
   logic [1:0]     cfg_mode = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [P-1:0]   in_data = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [C*U-1:0] out_data;
   logic           busy;

   int n_chk = 0;
   int n_fail = 0;
   int edge_cnt = 0;
   int m_pos [C];
   int m_w   [C];
   int m_mode[C];
   logic [C*U-1:0] exp_q[$];
   logic [C*U-1:0] got_q[$];
   logic [P-1:0]   beat_q[$];

   saph_num_unpack_stream #(.pack_width(P), .unpack_width(U), .channels(C)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pos(cfg_pos),
      .cfg_width(cfg_width), .cfg_mode(cfg_mode), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [U-1:0] model_ch(input logic [P-1:0] d, input int pos, input int w, input int mode);
      longint unsigned f, acc;
      int bits;
      logic [63:0] r;
      r = '0;
      if (w != 0) begin
         f = (longint'(d) >> pos) & ((64'd1 << w) - 1);
         case (mode)
            0: begin
               acc = 0; bits = 0;
               while (bits < U) begin acc = (acc << w) | f; bits += w; end
               r = acc >> (bits - U);
            end
            1: r = f;
            2: r = (f >= (64'd1 << (w - 1))) ? f - (64'd1 << w) : f;
            default: r = f << (U - w);
         endcase
      end
      return r[U-1:0];
   endfunction

   function automatic logic [C*U-1:0] model_beat(input logic [P-1:0] d);
      logic [C*U-1:0] res;
      for (int c = 0; c < C; c++) res[c*U +: U] = model_ch(d, m_pos[c], m_w[c], m_mode[c]);
      return res;
   endfunction

   // Bookkeeping only: beats are modelled with the table as it stood before this edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < C; c++) begin m_pos[c] = 0; m_w[c] = 0; m_mode[c] = 0; end
         exp_q.delete();
         got_q.delete();
      end else begin
         if (in_valid && in_ready) exp_q.push_back(model_beat(in_data));
         if (out_valid && out_ready) got_q.push_back(out_data);
         if (cfg_we && (int'(cfg_ch) < C)) begin
            m_pos[cfg_ch]  = int'(cfg_pos);
            m_w[cfg_ch]    = (int'(cfg_width) > U) ? U : int'(cfg_width);
            m_mode[cfg_ch] = int'(cfg_mode);
         end
      end
   end

   task automatic cfg_write(input int ch, input int pos, input int w, input int mode);
      cfg_we = 1'b1; cfg_ch = CE'(ch); cfg_pos = PE'(pos); cfg_width = UE'(w); cfg_mode = 2'(mode);
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic cfg_random();
      for (int c = 0; c < C; c++) cfg_write(c, $urandom_range(0, P-1), $urandom_range(0, 15), $urandom_range(0, 3));
   endtask

   // rmode 0: out_ready high; 1: pattern 1,0,0 repeating; 2: random ready and valid.
   task automatic stream(input int rmode, output int span);
      int n, sent, rcvd, cyc, first_acc;
      logic stalled;
      logic [C*U-1:0] held;
      n = beat_q.size(); sent = 0; rcvd = 0; cyc = 0; first_acc = -1; span = 0;
      stalled = 1'b0; held = '0;
      while ((sent < n || rcvd < n) && cyc < 400) begin
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         in_valid = (sent < n) && (rmode != 2 || $urandom_range(0, 3) != 0);
         if (sent < n) in_data = beat_q[sent];
         @(negedge clk);
         if (stalled) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               n_fail++;
               $display("FAIL hold_stable: out_valid=%b out_data=%h, required 1 and %h", out_valid, out_data, held);
            end
         end
         stalled = out_valid && !out_ready;
         held = out_data;
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = edge_cnt + 1;
            sent++;
         end
         if (out_valid && out_ready) begin
            rcvd++;
            span = edge_cnt + 1 - first_acc;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_chk++;
      if (rcvd != n) begin
         n_fail++;
         $display("FAIL stream_count: got %0d beats, required %0d", rcvd, n);
      end
      beat_q.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_state: ready/valid/busy=%b data=%h, required 000 and 0", {in_ready, out_valid, busy}, out_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_rgb565();
      logic [C*U-1:0] req[3];
      int span;
      req = '{24'h0000FF, 24'h080808, 24'hFFFFFF};
      cfg_write(0, 11, 5, 0);
      cfg_write(1, 5, 6, 0);
      cfg_write(2, 0, 5, 0);
      beat_q = '{16'hF800, 16'h0841, 16'hFFFF};
      stream(0, span);
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (got_q.size() == 0 || got_q[0] !== req[i]) begin
            n_fail++;
            $display("FAIL rgb565_%0d: got %h, required %h", i, (got_q.size() != 0) ? got_q[0] : 'x, req[i]);
         end
         if (got_q.size() != 0) void'(got_q.pop_front());
      end
      exp_q.delete();
   endtask

   task automatic test_modes();
      logic [C*U-1:0] req[4];
      logic [P-1:0] din[4];
      int span;
      req = '{24'hFA0AAA, 24'h0A00A0, 24'hC30030, 24'h000300};
      din = '{16'h000A, 16'h000A, 16'h00C3, 16'hC000};
      for (int b = 0; b < 4; b++) begin
         case (b)
            0: begin cfg_write(0, 0, 4, 0); cfg_write(1, 0, 4, 1); cfg_write(2, 0, 4, 2); end
            1: begin cfg_write(0, 0, 4, 3); cfg_write(1, 0, 0, 0); cfg_write(2, 0, 15, 1); end
            3: begin cfg_write(1, 14, 4, 1); cfg_write(3, 0, 8, 0); end
            default: ;
         endcase
         beat_q.push_back(din[b]);
         stream(0, span);
         n_chk++;
         if (got_q.size() != 1 || got_q[0] !== req[b]) begin
            n_fail++;
            $display("FAIL modes_%0d: got %h (count %0d), required %h", b, (got_q.size() != 0) ? got_q[0] : 'x, got_q.size(), req[b]);
         end
         got_q.delete();
         exp_q.delete();
      end
   endtask

   task automatic test_inflight_fmt();
      logic [C*U-1:0] req[3];
      req = '{24'h000005, 24'h000005, 24'h00000A};
      cfg_write(0, 0, 4, 1); cfg_write(1, 0, 0, 0); cfg_write(2, 0, 0, 0);
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'h00A5;
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_pos = 4'd4; cfg_width = 4'd4; cfg_mode = 2'd1;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (got_q.size() == 0 || got_q[0] !== req[i]) begin
            n_fail++;
            $display("FAIL inflight_fmt_%0d: got %h, required %h", i, (got_q.size() != 0) ? got_q[0] : 'x, req[i]);
         end
         if (got_q.size() != 0) void'(got_q.pop_front());
      end
      exp_q.delete();
   endtask

   task automatic test_full_stall();
      logic [C*U-1:0] g, e;
      cfg_random();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 16'($urandom);
      @(posedge clk); #1;
      in_data = 16'($urandom);
      @(posedge clk); #1;
      in_data = 16'($urandom);
      n_chk++;
      if ({in_ready, out_valid, busy} !== 3'b011) begin
         n_fail++;
         $display("FAIL full_stall: ready/valid/busy=%b, required 011", {in_ready, out_valid, busy});
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_ready_comb: got %b, required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_chk++;
      if (got_q.size() != 3 || exp_q.size() != 3) begin
         n_fail++;
         $display("FAIL full_stall_count: got %0d beats, required 3 (model %0d)", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL full_stall_data: got %h, required %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [C*U-1:0] g, e;
      int span;
      cfg_random();
      for (int i = 0; i < 8; i++) beat_q.push_back(16'($urandom));
      stream(0, span);
      n_chk++;
      if (span != 9) begin n_fail++; $display("FAIL b2b_cycles: got %0d, required 9", span); end
      n_chk++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d, required %0d", got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         n_chk++;
         if (g !== e) begin n_fail++; $display("FAIL b2b_data: got %h, required %h", g, e); end
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_backpressure(input int rmode, input int rounds);
      logic [C*U-1:0] g, e;
      int span;
      for (int r = 0; r < rounds; r++) begin
         cfg_random();
         for (int i = 0; i < 8 + 2 * rmode; i++) beat_q.push_back(16'($urandom));
         stream(rmode, span);
         n_chk++;
         if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp%0d_count: got %0d, required %0d", rmode, got_q.size(), exp_q.size());
         end
         while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            n_chk++;
            if (g !== e) begin n_fail++; $display("FAIL bp%0d_data: got %h, required %h", rmode, g, e); end
         end
         got_q.delete(); exp_q.delete();
      end
   endtask

   task automatic test_reset_midflight();
      int span;
      cfg_write(0, 0, 8, 1); cfg_write(1, 8, 8, 1);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 16'h5AA5;
      repeat (2) @(posedge clk);
      #1;
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== '0) begin
         n_fail++;
         $display("FAIL reset_midflight: ready/valid/busy=%b data=%h, required 000 and 0", {in_ready, out_valid, busy}, out_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      n_chk++;
      if (got_q.size() != 0 || out_data !== '0) begin
         n_fail++;
         $display("FAIL stale_beat: got %0d beats data %h, required 0 beats data 0", got_q.size(), out_data);
      end
      beat_q.push_back(16'hFFFF);
      stream(0, span);
      n_chk++;
      if (got_q.size() != 1 || got_q[0] !== '0) begin
         n_fail++;
         $display("FAIL table_cleared: got %h (count %0d), required 0", (got_q.size() != 0) ? got_q[0] : 'x, got_q.size());
      end
      got_q.delete(); exp_q.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rgb565();
      test_modes();
      test_inflight_fmt();
      test_full_stall();
      test_back_to_back();
      test_backpressure(1, 1);
      test_backpressure(2, 4);
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/saph_num_unpack_stream.md
# saph_num_unpack_stream

Streaming multi-channel bit-field unpacker. Each accepted beat holds `channels` fields. For each field, the block extracts the field from a packed word at a per-channel bit position and width. It then expands the field to a fixed `unpack_width` using a per-channel mode (unorm replication, zero-extend, sign-extend or MSB-align). The block sits between texture/vertex fetch and the shader/raster datapath. It is a 2-stage valid/ready pipeline with a runtime-writable format table.

## Interface
- `pack_width`, 16, width of packed input word, 2+.
- `unpack_width`, 8, width of each unpacked channel, 2+.
- `channels`, 4, number of channels per beat, 1+.
- localparam `pack_exp` = $clog2(pack_width); `unpack_exp` = $clog2(unpack_width+1); `ch_exp` = max(1, $clog2(channels)).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_we` in 1: format table write strobe.
- `cfg_ch` in `ch_exp`: channel index to write; values ≥ `channels` are ignored.
- `cfg_pos` in `pack_exp`: field LSB position.
- `cfg_width` in `unpack_exp`: field width in bits; 0 means the channel outputs constant 0.
- `cfg_mode` in 2: 0 = replicate, 1 = zero-extend, 2 = sign-extend, 3 = MSB-align.
- `in_valid` in 1, `in_ready` out 1, `in_data` in `pack_width`: input beat.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `channels*unpack_width`: channel c occupies bits [c*U +: U].
- `busy` out 1: any pipeline stage holds a beat.

## Operation
- Format table: per channel {pos, width, mode}, reset to all zero. A write on cycle N is visible to beats accepted on cycle N+1 or later.
- Width clamp: an effective width w = min(cfg_width, unpack_width) is applied at write time, so the stored width is never greater than U.
- Stage 1 (accept): on `in_valid && in_ready`, for each channel it registers raw = (in_data >> pos) masked to w bits, plus w and mode. Bits above `pack_width` read as 0. The format is snapshotted with the beat, so later cfg writes never alter in-flight beats.
- Stage 2 (expand): per channel, with v = raw and U = unpack_width:
  - w = 0: out = 0 in all modes.
  - mode 0: output bit i = v[w-1-((U-1-i) mod w)], i.e. MSB-first repetition of v.
  - mode 1: out = v zero-extended.
  - mode 2: out = v sign-extended from bit w-1.
  - mode 3: out = v << (U-w).
- Mode 0 with w = U, and modes 1/2 with w = U, are identity.
- Pipeline control:
  - s2 advances when !s2_valid || out_ready.
  - s1 moves to s2 when s1_valid && s2 advances.
  - `in_ready` = !s1_valid || (s1 moves to s2).
  - Throughput is 1 beat/cycle with no bubbles under continuous `out_ready`.
- `out_data` and `out_valid` are registered and stable while `out_valid && !out_ready`.
- `busy` = s1_valid || s2_valid.

## Timing
- Latency: a beat accepted at edge N appears with `out_valid` = 1 after edge N+1, i.e. 2 cycles accept-to-output.
- Reset (async assert, synchronous-to-clk release is the caller's responsibility):
  - `out_valid` = 0, `out_data` = 0, `busy` = 0, format table = 0.
  - `in_ready` = 0 while `rst_n` is low and 1 from the first cycle after release.
- Reset mid-operation: all in-flight beats are dropped, no partial output, and the format table is cleared.
- Simultaneous `cfg_we` and accept on the same edge: the accepted beat uses the old format.
- Full pipeline with `out_ready` = 0: `in_ready` = 0. Releasing `out_ready` for one cycle frees one slot, and `in_ready` rises combinationally in that same cycle.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` to `out_valid`.

## Test plan
- RGB565 (pack 16, U 8, ch 3: R pos11 w5 m0, G pos5 w6 m0, B pos0 w5 m0):
  - in 0xF800 → R=0xFF G=0x00 B=0x00.
  - in 0x0841 → 0x08, 0x08, 0x08.
  - in 0xFFFF → 0xFF ×3.
- Modes on pos0 w4, in 0x000A:
  - m0 → 0xAA; m1 → 0x0A; m2 → 0xFA; m3 → 0xA0.
  - w0 → 0x00.
  - cfg_width 15 clamps to 8: in 0x00C3 pos0 → 0xC3.
- Field past top: pos14 w4 m1, in 0xC000 → 0x03.
- Backpressure:
  - Stream 8 beats with `out_ready` toggling 1,0,0,1,…: all 8 outputs arrive in order with no loss or duplication, and `out_data` is held stable while stalled.
  - With `out_ready` = 1 for the whole stream: 8 beats complete in 9 cycles (plus the initial latency).
- Format change in flight: accept A with fmt X, write fmt Y the next cycle, accept B → A expands with X and B with Y.
- Assert `rst_n` low with 2 beats in flight → `out_valid` and `busy` drop immediately. After release, outputs are zero and no stale beat is emitted.
